pipe_hazard_ctrl: RTL
=====================

# pipe_hazard_ctrl

Pipeline sequencing controller for the five-stage MIPS core. It decides each cycle whether PC, IF/ID, ID/EX, EX/MEM and MEM/WB advance, hold, flush or take a bubble. It covers three cases:
- load-use hazards, checked against the ID/EX register contents;
- taken-branch squashes;
- multi-cycle data-memory waits, with a timeout watchdog.

It also keeps a saturating count of stall cycles for performance measurement. It sits beside the pipeline registers and drives their stall/flush inputs.

## Interface
Parameters:
- MEM_TIMEOUT, 64: maximum consecutive memory-wait cycles before the error state is entered (2..65535).
- CNT_W, 16: width of the stall-cycle counter.

Ports:
- clk  input  1  pipeline clock. All state updates on the falling edge, the same edge the pipeline registers use.
- rst  input  1  synchronous, active-high reset.
- id_rs  input  5  rs field of the instruction in ID.
- id_rt  input  5  rt field of the instruction in ID.
- id_uses_rt  input  1  the ID instruction reads rt as a source.
- ex_rt  input  5  rt held in the ID/EX register (rt_3).
- ex_MemRead  input  1  MemRead held in the ID/EX register (MemRead_3).
- branch_taken  input  1  branch resolved taken in EX this cycle.
- dmem_req  input  1  MEM stage is accessing data memory.
- dmem_ready  input  1  data memory completes the access this cycle.
- pc_hold  output  1  PC keeps its value.
- ifid_hold  output  1  IF/ID keeps its value.
- ifid_flush  output  1  IF/ID loads a NOP.
- idex_bubble  output  1  ID/EX control fields are zeroed (drives id_ex stall).
- idex_hold  output  1  ID/EX keeps all fields.
- exmem_hold  output  1  EX/MEM keeps its value.
- memwb_bubble  output  1  MEM/WB loads RegWr=0, MemtoReg=0.
- timeout_err  output  1  sticky memory-timeout flag.
- stall_cnt  output  CNT_W  saturating count of cycles with pc_hold=1.

## Operation
FSM states: RUN, MEMWAIT, ERR. Control outputs are Mealy, combinational from state and inputs. A signal not listed for a case is 0.

While rst=1:
- Next state is RUN; wait_cnt=0, stall_cnt=0, timeout_err=0.
- Control outputs are forced to idex_bubble=1, memwb_bubble=1, all others 0.

RUN priority is highest first:
1. Memory wait: dmem_req=1 and dmem_ready=0.
   - pc_hold, ifid_hold, idex_hold, exmem_hold and memwb_bubble all =1.
   - Next state MEMWAIT, wait_cnt<=1.
2. Branch: branch_taken=1.
   - ifid_flush=1, idex_bubble=1, PC advances.
   - This overrides a simultaneous load-use hazard, because the ID instruction is squashed.
3. Load-use: ex_MemRead=1 and ex_rt!=0 and (ex_rt==id_rs or (id_uses_rt and ex_rt==id_rt)).
   - pc_hold=1, ifid_hold=1, idex_bubble=1.
4. Otherwise all control outputs are 0.

MEMWAIT:
- dmem_ready=1: all control outputs 0 and the pipeline advances; next state RUN, wait_cnt<=0. Load-use and branch are not evaluated in this cycle; they are evaluated from the next RUN cycle.
- dmem_ready=0: same outputs as RUN case 1.
  - If wait_cnt==MEM_TIMEOUT-1: next state ERR, timeout_err<=1.
  - Otherwise wait_cnt<=wait_cnt+1.
- dmem_req dropping while in MEMWAIT is treated as ready.

ERR:
- pc_hold, ifid_hold, idex_hold, exmem_hold and memwb_bubble all =1.
- timeout_err stays 1. Only rst leaves ERR.

Counters:
- wait_cnt is internal and 16 bits wide.
- stall_cnt increments on every falling edge where pc_hold=1 and rst=0, and saturates at all-ones.

## Timing
- Hazard response is zero-latency: outputs react in the same cycle as the inputs and are sampled by the pipeline registers on that falling edge.
- A load-use stall lasts exactly 1 cycle. The next cycle sees ex_MemRead=0 from the bubble, so no hazard is flagged.
- Memory-wait freeze lasts N+1 cycles for a response arriving N cycles after entry, counting the release cycle with outputs 0.
- The ERR transition happens on the edge that ends the MEM_TIMEOUT-th consecutive not-ready cycle.
- rst asserted mid-MEMWAIT or in ERR returns the FSM to RUN on that edge.

## Test plan
- Load-use: ex_MemRead=1, ex_rt=5, id_rs=5 -> one cycle of pc_hold=ifid_hold=idex_bubble=1, stall_cnt goes 0->1, then all outputs 0.
- Register $0 and an unused rt:
  - ex_rt=0=id_rs with ex_MemRead=1 -> no stall.
  - ex_rt=7=id_rt with id_uses_rt=0 -> no stall.
- Branch during a load-use hazard: branch_taken=1 and the hazard condition together -> ifid_flush=1, idex_bubble=1, pc_hold=0.
- Memory wait of 3 cycles: dmem_req=1, dmem_ready low 3 cycles then high -> holds and memwb_bubble high 3 cycles, outputs 0 in the 4th, stall_cnt=3.
- Timeout: MEM_TIMEOUT=4, dmem_ready held 0 -> timeout_err=1 after the 4th edge; holds stay asserted regardless of dmem_ready; rst -> RUN, timeout_err=0, stall_cnt=0.
- Saturation: CNT_W=4 with 20 load-use stalls -> stall_cnt stays at 15.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller for the five-stage MIPS core.
// Ports: clk, rst (sync, active high); ID/EX hazard fields id_rs,
//   id_rt, id_uses_rt, ex_rt, ex_MemRead; branch_taken; dmem_req,
//   dmem_ready; stage controls pc_hold, ifid_hold, ifid_flush,
//   idex_bubble, idex_hold, exmem_hold, memwb_bubble; timeout_err
//   (sticky); stall_cnt (saturating count of pc_hold cycles).
module pipe_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rt,
    input  logic [4:0]       ex_rt,
    input  logic             ex_MemRead,
    input  logic             branch_taken,
    input  logic             dmem_req,
    input  logic             dmem_ready,
    output logic             pc_hold,
    output logic             ifid_hold,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic             idex_hold,
    output logic             exmem_hold,
    output logic             memwb_bubble,
    output logic             timeout_err,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef enum logic [1:0] {RUN, MEMWAIT, ERR} state_t;

    localparam logic [15:0] WAIT_LAST = 16'(MEM_TIMEOUT - 1);

    state_t      state;
    logic [15:0] wait_cnt;
    logic        load_use;
    logic        mem_stall;
    logic        freeze;
    logic        squash;
    logic        lu_stall;

    assign load_use = ex_MemRead && (ex_rt != 5'd0) &&
                      ((ex_rt == id_rs) ||
                       (id_uses_rt && (ex_rt == id_rt)));

    // A dropped request counts as completion, so only req&&!ready waits.
    assign mem_stall = dmem_req && !dmem_ready;

    always_comb begin
        freeze   = 1'b0;
        squash   = 1'b0;
        lu_stall = 1'b0;
        if (!rst) begin
            unique case (state)
                RUN: begin
                    if (mem_stall)
                        freeze = 1'b1;
                    else if (branch_taken)
                        squash = 1'b1;
                    else if (load_use)
                        lu_stall = 1'b1;
                end
                MEMWAIT: freeze = mem_stall;
                ERR:     freeze = 1'b1;
                default: freeze = 1'b1;
            endcase
        end
    end

    // Reset presents a bubble to ID/EX and MEM/WB so nothing commits.
    assign pc_hold      = freeze | lu_stall;
    assign ifid_hold    = freeze | lu_stall;
    assign ifid_flush   = squash;
    assign idex_bubble  = rst | squash | lu_stall;
    assign idex_hold    = freeze;
    assign exmem_hold   = freeze;
    assign memwb_bubble = rst | freeze;

    // Falling edge: the same edge the pipeline registers load on.
    always_ff @(negedge clk) begin
        if (rst) begin
            state       <= RUN;
            wait_cnt    <= 16'd0;
            timeout_err <= 1'b0;
            stall_cnt   <= '0;
        end else begin
            if (pc_hold && (stall_cnt != '1))
                stall_cnt <= stall_cnt + 1'b1;
            unique case (state)
                RUN: begin
                    if (mem_stall) begin
                        state    <= MEMWAIT;
                        wait_cnt <= 16'd1;
                    end
                end
                MEMWAIT: begin
                    if (!mem_stall) begin
                        state    <= RUN;
                        wait_cnt <= 16'd0;
                    end else if (wait_cnt == WAIT_LAST) begin
                        state       <= ERR;
                        timeout_err <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 16'd1;
                    end
                end
                ERR:     timeout_err <= 1'b1;
                default: state <= ERR;
            endcase
        end
    end

endmodule
